// File: rtl/reset_sequencer.sv
// Central reset controller: staggered release of video, Z80 and 68K resets after
// power-up or a watchdog bite, plus a saturating bite counter for diagnostics.
module reset_sequencer #(
    parameter int WD_LIMIT = 8,
    parameter int HOLD_CYC = 16,
    parameter int STAGGER  = 8
) (
    input  logic       nSNKCLK11,
    input  logic       PSTRESET,
    input  logic       TICK,
    input  logic       nWDKICK,
    input  logic       WD_EN,
    output logic       nRESET_VID,
    output logic       nRESET_Z80,
    output logic       nRESET_68K,
    output logic       nWDRESET,
    output logic [7:0] FIRE_CNT,
    output logic [1:0] dbg_state_o
);

    localparam int WDW = $clog2(WD_LIMIT + 1);
    localparam logic [15:0]    HOLD_LAST = 16'(HOLD_CYC - 1);
    localparam logic [15:0]    STAG_LAST = 16'(STAGGER - 1);
    localparam logic [WDW-1:0] WD_LAST   = WDW'(WD_LIMIT - 1);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        REL_VID = 2'd1,
        REL_Z80 = 2'd2,
        RUN     = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    timer_q, timer_d;
    logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
    logic           cause_q, cause_d;
    logic [7:0]     fire_q, fire_d;
    logic           kick_prev_q;
    logic           vid_q, vid_d;
    logic           z80_q, z80_d;
    logic           m68k_q, m68k_d;
    logic           kick;

    // A kick is the falling edge of the strobe, so a held-low strobe counts once.
    assign kick = kick_prev_q & ~nWDKICK;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        wd_cnt_d = wd_cnt_q;
        cause_d  = cause_q;
        fire_d   = fire_q;
        vid_d    = vid_q;
        z80_d    = z80_q;
        m68k_d   = m68k_q;
        case (state_q)
            HOLD: begin
                vid_d    = 1'b0;
                z80_d    = 1'b0;
                m68k_d   = 1'b0;
                wd_cnt_d = '0;
                if (timer_q == HOLD_LAST) begin
                    state_d = REL_VID;
                    timer_d = '0;
                    vid_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            REL_VID: begin
                wd_cnt_d = '0;
                if (timer_q == STAG_LAST) begin
                    state_d = REL_Z80;
                    timer_d = '0;
                    z80_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            REL_Z80: begin
                wd_cnt_d = '0;
                if (timer_q == STAG_LAST) begin
                    state_d = RUN;
                    timer_d = '0;
                    m68k_d  = 1'b1;
                    cause_d = 1'b0;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            RUN: begin
                // Kick takes priority over a TICK arriving on the same edge.
                if (kick || !WD_EN) begin
                    wd_cnt_d = '0;
                end else if (TICK && (wd_cnt_q == WD_LAST)) begin
                    state_d  = HOLD;
                    timer_d  = '0;
                    wd_cnt_d = '0;
                    vid_d    = 1'b0;
                    z80_d    = 1'b0;
                    m68k_d   = 1'b0;
                    cause_d  = 1'b1;
                    if (fire_q != 8'hFF) begin
                        fire_d = fire_q + 8'd1;
                    end
                end else if (TICK) begin
                    wd_cnt_d = wd_cnt_q + WDW'(1);
                end
            end
            default: begin
                state_d = HOLD;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge nSNKCLK11 or negedge PSTRESET) begin
        if (!PSTRESET) begin
            state_q     <= HOLD;
            timer_q     <= '0;
            wd_cnt_q    <= '0;
            cause_q     <= 1'b0;
            fire_q      <= '0;
            kick_prev_q <= 1'b1;
            vid_q       <= 1'b0;
            z80_q       <= 1'b0;
            m68k_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            wd_cnt_q    <= wd_cnt_d;
            cause_q     <= cause_d;
            fire_q      <= fire_d;
            kick_prev_q <= nWDKICK;
            vid_q       <= vid_d;
            z80_q       <= z80_d;
            m68k_q      <= m68k_d;
        end
    end

    assign nRESET_VID  = vid_q;
    assign nRESET_Z80  = z80_q;
    assign nRESET_68K  = m68k_q;
    assign nWDRESET    = ~cause_q;
    assign FIRE_CNT    = fire_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: release timing, watchdog bite/kick/enable behaviour,
// async reset mid-sequence and bite-counter saturation (second instance, WD_LIMIT=1).
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       nkick = 1'b1;
    logic       wd_en = 1'b1;
    logic       n_vid, n_z80, n_68k, n_wd;
    logic [7:0] fire;
    logic [1:0] dbg;

    logic       rst2_n = 1'b0;
    logic       tick2 = 1'b0;
    logic       n_vid2, n_z802, n_68k2, n_wd2;
    logic [7:0] fire2;
    logic [1:0] dbg2;

    logic [11:0] exp_q[$];
    logic [11:0] exp_v, got_v;
    int tests_run = 0;
    int failed = 0;

    always #5 clk = ~clk;

    reset_sequencer dut (
        .nSNKCLK11(clk), .PSTRESET(rst_n), .TICK(tick), .nWDKICK(nkick), .WD_EN(wd_en),
        .nRESET_VID(n_vid), .nRESET_Z80(n_z80), .nRESET_68K(n_68k), .nWDRESET(n_wd),
        .FIRE_CNT(fire), .dbg_state_o(dbg)
    );

    reset_sequencer #(.WD_LIMIT(1), .HOLD_CYC(1), .STAGGER(1)) dut_sat (
        .nSNKCLK11(clk), .PSTRESET(rst2_n), .TICK(tick2), .nWDKICK(1'b1), .WD_EN(1'b1),
        .nRESET_VID(n_vid2), .nRESET_Z80(n_z802), .nRESET_68K(n_68k2), .nWDRESET(n_wd2),
        .FIRE_CNT(fire2), .dbg_state_o(dbg2)
    );

    function automatic logic [11:0] pack(input logic v, input logic z, input logic m,
                                         input logic w, input logic [7:0] f);
        return {v, z, m, w, f};
    endfunction

    function automatic logic [11:0] obs();
        return {n_vid, n_z80, n_68k, n_wd, fire};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b1, 8'd0));
        exp_v = exp_q.pop_front(); got_v = obs(); tests_run++;
        if (got_v !== exp_v) begin
            failed++; $display("FAIL reset_outputs got %h want %h", got_v, exp_v);
        end
        tests_run++;
        if (dbg !== 2'd0) begin
            failed++; $display("FAIL reset_state got %0d want 0", dbg);
        end
    endtask

    task automatic test_powerup();
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            exp_q.push_back(pack(k >= 16, k >= 24, k >= 32, 1'b1, 8'd0));
            step();
            exp_v = exp_q.pop_front(); got_v = obs(); tests_run++;
            if (got_v !== exp_v) begin
                failed++; $display("FAIL powerup edge %0d got %h want %h", k, got_v, exp_v);
            end
        end
        tests_run++;
        if (dbg !== 2'd3) begin
            failed++; $display("FAIL powerup_state got %0d want 3", dbg);
        end
    endtask

    task automatic test_bite();
        for (int i = 1; i <= 8; i++) begin
            tick = 1'b1;
            if (i < 8) exp_q.push_back(pack(1'b1, 1'b1, 1'b1, 1'b1, 8'd0));
            else       exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
            step();
            tick = 1'b0;
            exp_v = exp_q.pop_front(); got_v = obs(); tests_run++;
            if (got_v !== exp_v) begin
                failed++; $display("FAIL bite tick %0d got %h want %h", i, got_v, exp_v);
            end
            if (i < 8) step();
        end
        for (int k = 1; k <= 40; k++) begin
            exp_q.push_back(pack(k >= 16, k >= 24, k >= 32, k >= 32, 8'd1));
            step();
            exp_v = exp_q.pop_front(); got_v = obs(); tests_run++;
            if (got_v !== exp_v) begin
                failed++; $display("FAIL bite_release edge %0d got %h want %h", k, got_v, exp_v);
            end
        end
    endtask

    task automatic test_kick();
        for (int i = 1; i <= 7; i++) begin
            tick = 1'b1; step(); tick = 1'b0; step();
        end
        nkick = 1'b0; step(); step(); step();
        nkick = 1'b1; step();
        for (int i = 1; i <= 7; i++) begin
            tick = 1'b1;
            exp_q.push_back(pack(1'b1, 1'b1, 1'b1, 1'b1, 8'd1));
            step();
            tick = 1'b0;
            exp_v = exp_q.pop_front(); got_v = obs(); tests_run++;
            if (got_v !== exp_v) begin
                failed++; $display("FAIL kick_after tick %0d got %h want %h", i, got_v, exp_v);
            end
            step();
        end
        // Counter now sits one short of a bite; kick on the same edge as the tick.
        tick = 1'b1; nkick = 1'b0;
        exp_q.push_back(pack(1'b1, 1'b1, 1'b1, 1'b1, 8'd1));
        step();
        tick = 1'b0;
        exp_v = exp_q.pop_front(); got_v = obs(); tests_run++;
        if (got_v !== exp_v) begin
            failed++; $display("FAIL kick_with_tick got %h want %h", got_v, exp_v);
        end
        step();
        for (int i = 1; i <= 8; i++) begin
            tick = 1'b1;
            if (i < 8) exp_q.push_back(pack(1'b1, 1'b1, 1'b1, 1'b1, 8'd1));
            else       exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, 8'd2));
            step();
            tick = 1'b0;
            exp_v = exp_q.pop_front(); got_v = obs(); tests_run++;
            if (got_v !== exp_v) begin
                failed++; $display("FAIL kick_held tick %0d got %h want %h", i, got_v, exp_v);
            end
            if (i < 8) step();
        end
        nkick = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            if (k >= 31) begin
                exp_q.push_back(pack(1'b1, 1'b1, k >= 32, k >= 32, 8'd2));
                exp_v = exp_q.pop_front(); got_v = obs(); tests_run++;
                if (got_v !== exp_v) begin
                    failed++; $display("FAIL kick_release edge %0d got %h want %h", k, got_v, exp_v);
                end
            end
        end
    endtask

    task automatic test_wd_en();
        wd_en = 1'b0;
        tick = 1'b1;
        for (int k = 1; k <= 1000; k++) begin
            step();
            if (k % 250 == 0) begin
                exp_q.push_back(pack(1'b1, 1'b1, 1'b1, 1'b1, 8'd2));
                exp_v = exp_q.pop_front(); got_v = obs(); tests_run++;
                if (got_v !== exp_v) begin
                    failed++; $display("FAIL wd_disabled tick %0d got %h want %h", k, got_v, exp_v);
                end
            end
        end
        tick = 1'b0;
        wd_en = 1'b1;
        step();
        for (int i = 1; i <= 8; i++) begin
            tick = 1'b1;
            if (i < 8) exp_q.push_back(pack(1'b1, 1'b1, 1'b1, 1'b1, 8'd2));
            else       exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, 8'd3));
            step();
            tick = 1'b0;
            exp_v = exp_q.pop_front(); got_v = obs(); tests_run++;
            if (got_v !== exp_v) begin
                failed++; $display("FAIL wd_enabled tick %0d got %h want %h", i, got_v, exp_v);
            end
            if (i < 8) step();
        end
        repeat (32) step();
        exp_q.push_back(pack(1'b1, 1'b1, 1'b1, 1'b1, 8'd3));
        exp_v = exp_q.pop_front(); got_v = obs(); tests_run++;
        if (got_v !== exp_v) begin
            failed++; $display("FAIL wd_en_release got %h want %h", got_v, exp_v);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 1; i <= 8; i++) begin
            tick = 1'b1; step(); tick = 1'b0;
            if (i < 8) step();
        end
        exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, 8'd4));
        exp_v = exp_q.pop_front(); got_v = obs(); tests_run++;
        if (got_v !== exp_v) begin
            failed++; $display("FAIL async_bite got %h want %h", got_v, exp_v);
        end
        repeat (26) step();
        exp_q.push_back(pack(1'b1, 1'b1, 1'b0, 1'b0, 8'd4));
        exp_v = exp_q.pop_front(); got_v = obs(); tests_run++;
        if (got_v !== exp_v || dbg !== 2'd2) begin
            failed++; $display("FAIL async_in_rel_z80 got %h st %0d want %h st 2", got_v, dbg, exp_v);
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b1, 8'd0));
        exp_v = exp_q.pop_front(); got_v = obs(); tests_run++;
        if (got_v !== exp_v || dbg !== 2'd0) begin
            failed++; $display("FAIL async_assert got %h st %0d want %h st 0", got_v, dbg, exp_v);
        end
        repeat (3) step();
        rst_n = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            exp_q.push_back(pack(k >= 16, k >= 24, k >= 32, 1'b1, 8'd0));
            step();
            exp_v = exp_q.pop_front(); got_v = obs(); tests_run++;
            if (got_v !== exp_v) begin
                failed++; $display("FAIL async_restart edge %0d got %h want %h", k, got_v, exp_v);
            end
        end
    endtask

    task automatic test_saturation();
        step();
        rst2_n = 1'b1;
        tick2 = 1'b1;
        // With all parameters at 1 and TICK held high, each bite takes exactly 4 edges.
        for (int e = 1; e <= 1032; e++) begin
            step();
            if (e == 3 || e == 4 || e == 1016 || e == 1020 || e == 1028 || e == 1032) begin
                if (e == 3)         exp_q.push_back({4'h0, 8'd0});
                else if (e == 4)    exp_q.push_back({4'h0, 8'd1});
                else if (e == 1016) exp_q.push_back({4'h0, 8'd254});
                else                exp_q.push_back({4'h0, 8'd255});
                exp_v = exp_q.pop_front(); got_v = {4'h0, fire2}; tests_run++;
                if (got_v !== exp_v) begin
                    failed++; $display("FAIL saturation edge %0d got %0d want %0d", e, got_v, exp_v);
                end
            end
        end
        tick2 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_powerup();
        test_bite();
        test_kick();
        test_wd_en();
        test_async_reset();
        test_saturation();
        tests_run++;
        if (exp_q.size() != 0) begin
            failed++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
